// File: rtl/logic_accum_pkg.sv
// Shared op codes, FSM encoding and fold identity for the streaming bitwise accumulator.
// Pure definitions; no logic, no latency, no flow control.
package logic_accum_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  // Widest datapath the identity helper can produce; callers size-cast down to WIDTH.
  localparam int MAX_W = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Starting accumulator value: all ones for AND, zero for OR/XOR (and the reserved code).
  function automatic logic [MAX_W-1:0] identity(input logic [1:0] op, input int width);
    logic [MAX_W-1:0] ones;
    ones = '1;
    if (op == OP_AND) return ~(ones << width);
    return '0;
  endfunction

endpackage

// File: rtl/logic_op.sv
// Two-operand bitwise unit (AND/OR/XOR, reserved code behaves as OR).
// Purely combinational; no state, no backpressure.
module logic_op
  import logic_accum_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    case (op)
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = a | b;
    endcase
  end

endmodule

// File: rtl/logic_accum.sv
// Folds a run of len operand words into one result with a latched bitwise op.
// Result valid the cycle after the last accepted beat; holds in DONE until out_ready.
module logic_accum
  import logic_accum_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_fold;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] len_q;
  logic [1:0]       op_q;
  logic             beat;

  assign cnt_inc = cnt + 1'b1;

  logic_op #(.WIDTH(WIDTH)) u_op (
    .a  (acc),
    .b  (in_data),
    .op (op_q),
    .y  (acc_fold)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake outputs depend only on the state register.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    beat      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? DONE : ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        beat     = in_valid;
        if (beat && (cnt_inc == len_q)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      op_q  <= OP_OR;
      len_q <= '0;
    end else if (state == IDLE && start) begin
      op_q  <= op;
      len_q <= len;
      acc   <= WIDTH'(identity(op, WIDTH));
      cnt   <= '0;
    end else if (beat) begin
      acc <= acc_fold;
      cnt <= cnt_inc;
    end
  end

  // acc/cnt are untouched after the handshake, so the last result stays visible in IDLE.
  assign out_data  = acc;
  assign out_count = cnt;

endmodule

// File: tb/tb_logic_accum.sv
// Self-checking bench for logic_accum: directed scenarios plus randomized runs
// compared against a queue-based fold model.
module tb_logic_accum;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic_accum #(.WIDTH(32), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Reference: start from the op's identity and fold each word in arrival order.
  function automatic logic [31:0] ref_fold(input logic [1:0] o, input logic [31:0] q[$]);
    logic [31:0] r;
    r = (o == 2'b00) ? 32'hffffffff : 32'h0;
    foreach (q[i]) begin
      if (o == 2'b00)      r = r & q[i];
      else if (o == 2'b10) r = r ^ q[i];
      else                 r = r | q[i];
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [1:0] o, input logic [7:0] l);
    start = 1'b1; op = o; len = l;
    step();
    start = 1'b0; op = 2'($urandom); len = 8'($urandom);
  endtask

  task automatic beat_word(input logic [31:0] d);
    in_valid = 1'b1; in_data = d;
    step();
    in_valid = 1'b0; in_data = $urandom;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({in_ready, out_valid, busy, out_data, out_count} !== 43'h0) begin
      errors++;
      $display("FAIL reset_async got rdy=%b vld=%b busy=%b data=%h cnt=%0d want all zero",
               in_ready, out_valid, busy, out_data, out_count);
    end
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if ({in_ready, out_valid, busy, out_data, out_count} !== 43'h0) begin
      errors++;
      $display("FAIL reset_idle got rdy=%b vld=%b busy=%b data=%h cnt=%0d want all zero",
               in_ready, out_valid, busy, out_data, out_count);
    end
  endtask

  task automatic test_or_continuous();
    arm(2'b01, 8'd3);
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b110) begin
      errors++;
      $display("FAIL or_acc_state got rdy=%b busy=%b vld=%b want 1 1 0", in_ready, busy, out_valid);
    end
    beat_word(32'hffff0000);
    beat_word(32'h0000ff00);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL or_early_valid got %b want 0", out_valid);
    end
    beat_word(32'h0000000f);
    checks++;
    if ({out_valid, in_ready, out_data, out_count} !== {1'b1, 1'b0, 32'hffffff0f, 8'd3}) begin
      errors++;
      $display("FAIL or_result got vld=%b rdy=%b data=%h cnt=%0d want 1 0 ffffff0f 3",
               out_valid, in_ready, out_data, out_count);
    end
    drain();
    checks++;
    if ({out_valid, busy, out_data, out_count} !== {1'b0, 1'b0, 32'hffffff0f, 8'd3}) begin
      errors++;
      $display("FAIL or_after_drain got vld=%b busy=%b data=%h cnt=%0d want 0 0 ffffff0f 3",
               out_valid, busy, out_data, out_count);
    end
  endtask

  task automatic test_and_gaps();
    arm(2'b00, 8'd2);
    beat_word(32'hffffffff);
    for (int g = 0; g < 3; g++) begin
      step();
      checks++;
      if ({in_ready, out_valid, out_count} !== {1'b1, 1'b0, 8'd1}) begin
        errors++;
        $display("FAIL and_gap%0d got rdy=%b vld=%b cnt=%0d want 1 0 1", g, in_ready, out_valid, out_count);
      end
    end
    beat_word(32'h007fa509);
    checks++;
    if ({out_valid, out_data, out_count} !== {1'b1, 32'h007fa509, 8'd2}) begin
      errors++;
      $display("FAIL and_result got vld=%b data=%h cnt=%0d want 1 007fa509 2", out_valid, out_data, out_count);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    arm(2'b10, 8'd2);
    beat_word(32'h007fa509);
    beat_word(32'hffffffff);
    checks++;
    if ({out_valid, out_data, out_count} !== {1'b1, 32'hff805af6, 8'd2}) begin
      errors++;
      $display("FAIL xor_result got vld=%b data=%h cnt=%0d want 1 ff805af6 2", out_valid, out_data, out_count);
    end
    // start during the DONE handshake cycle must be ignored
    start = 1'b1; op = 2'b00; len = 8'd5; out_ready = 1'b1;
    step();
    start = 1'b0; out_ready = 1'b0;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_idle got vld=%b busy=%b rdy=%b want 0 0 0", out_valid, busy, in_ready);
    end
    arm(2'b01, 8'd1);
    beat_word(32'h12345678);
    checks++;
    if ({out_valid, out_data, out_count} !== {1'b1, 32'h12345678, 8'd1}) begin
      errors++;
      $display("FAIL b2b_result got vld=%b data=%h cnt=%0d want 1 12345678 1", out_valid, out_data, out_count);
    end
    drain();
  endtask

  task automatic test_len_zero();
    in_valid = 1'b1;
    arm(2'b00, 8'd0);
    checks++;
    if ({out_valid, in_ready, out_data, out_count} !== {1'b1, 1'b0, 32'hffffffff, 8'd0}) begin
      errors++;
      $display("FAIL len0 got vld=%b rdy=%b data=%h cnt=%0d want 1 0 ffffffff 0",
               out_valid, in_ready, out_data, out_count);
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_hold();
    logic [31:0] d;
    d = $urandom;
    arm(2'b01, 8'd1);
    beat_word(d);
    for (int c = 0; c < 5; c++) begin
      start = c[0]; op = 2'($urandom); in_data = $urandom; in_valid = 1'($urandom);
      step();
      checks++;
      if ({out_valid, busy, in_ready, out_data, out_count} !== {3'b110, d, 8'd1}) begin
        errors++;
        $display("FAIL hold%0d got vld=%b busy=%b rdy=%b data=%h cnt=%0d want 1 1 0 %h 1",
                 c, out_valid, busy, in_ready, out_data, out_count, d);
      end
    end
    start = 1'b0; in_valid = 1'b0;
    drain();
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL hold_release got vld=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    arm(2'b01, 8'd4);
    beat_word(32'haa55aa55);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, out_data, out_count} !== 43'h0) begin
      errors++;
      $display("FAIL midrst got rdy=%b vld=%b busy=%b data=%h cnt=%0d want all zero",
               in_ready, out_valid, busy, out_data, out_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_idle got rdy=%b vld=%b busy=%b want 0 0 0", in_ready, out_valid, busy);
    end
    arm(2'b01, 8'd1);
    beat_word(32'h0000000f);
    checks++;
    if ({out_valid, out_data, out_count} !== {1'b1, 32'h0000000f, 8'd1}) begin
      errors++;
      $display("FAIL midrst_fresh got vld=%b data=%h cnt=%0d want 1 0000000f 1", out_valid, out_data, out_count);
    end
    drain();
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] exp;
    logic [1:0]  o;
    logic [7:0]  l;
    for (int r = 0; r < 16; r++) begin
      o = 2'($urandom_range(0, 3));
      l = (r == 7) ? 8'd255 : 8'($urandom_range(0, 10));
      q.delete();
      for (int i = 0; i < int'(l); i++) q.push_back($urandom);
      exp = ref_fold(o, q);
      arm(o, l);
      foreach (q[i]) begin
        repeat ($urandom_range(0, 2)) step();
        beat_word(q[i]);
      end
      checks++;
      if ({out_valid, out_data, out_count} !== {1'b1, exp, l}) begin
        errors++;
        $display("FAIL rand%0d op=%0d len=%0d got vld=%b data=%h cnt=%0d want 1 %h %0d",
                 r, o, l, out_valid, out_data, out_count, exp, l);
      end
      repeat ($urandom_range(0, 3)) step();
      drain();
      checks++;
      if ({out_valid, busy} !== 2'b00) begin
        errors++;
        $display("FAIL rand%0d_drain got vld=%b busy=%b want 0 0", r, out_valid, busy);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; len = 8'd0;
    in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    test_reset();
    test_or_continuous();
    test_and_gaps();
    test_back_to_back();
    test_len_zero();
    test_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
